// File: rtl/filter_sp_pkg.sv
// Shared definitions for the filter scratchpad unit: FSM state encoding and default widths.
package filter_sp_pkg;

  localparam int DEF_POINTER_SIZE = 8;
  localparam int DEF_DATA_WIDTH   = 16;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } sp_state_t;

endpackage

// File: rtl/filter_sp_mem.sv
// DEPTH x DATA_WIDTH scratchpad array: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module filter_sp_mem
  import filter_sp_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; only the read register is cleared so dout starts at 0.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/filter_scratchpad_unit.sv
// Filter scratchpad: stores filter words, owns write/read pointers, walks filter windows for the PE.
// Optional sticky err output is enabled by defining FILTER_SP_ERR_EN.
module filter_scratchpad_unit
  import filter_sp_pkg::*;
#(
  parameter int SP_SIZE              = 8,
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int POINTER_SIZE         = DEF_POINTER_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            write_en,
  input  logic                            write_counter_en,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  input  logic                            av_filter,
  input  logic                            end_of_filter,
  input  logic                            read_req,
  input  logic                            next_filter,
  output logic [POINTER_SIZE-1:0]         write_pointer,
  output logic [POINTER_SIZE-1:0]         read_pointer,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            dout_valid,
  output logic                            co_filter,
  output logic                            busy
`ifdef FILTER_SP_ERR_EN
  ,
  output logic                            err
`endif
);

  localparam int ADDR_WIDTH = (SP_SIZE > 1) ? $clog2(SP_SIZE) : 1;

  sp_state_t               state;
  logic [POINTER_SIZE-1:0] base;
  logic [POINTER_SIZE-1:0] idx;
  logic [POINTER_SIZE-1:0] fs_ext;
  logic [POINTER_SIZE-1:0] fs_last;
  logic                    full;
  logic                    write_ok;
  logic                    fire;
  logic                    last;

  assign fs_ext       = POINTER_SIZE'(filter_size);
  assign fs_last      = fs_ext - POINTER_SIZE'(1);
  assign full         = (write_pointer == POINTER_SIZE'(SP_SIZE));
  assign write_ok     = !full && (state != S_FLUSH);
  // end_of_filter wins over a same-cycle read: the read is dropped.
  assign fire         = read_req && av_filter && (state == S_ACTIVE) && !end_of_filter;
  assign last         = (idx == fs_last);
  assign read_pointer = base + idx;
  assign busy         = (state != S_EMPTY);

  filter_sp_mem #(
    .DEPTH      (SP_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (write_en && write_ok),
    .waddr (write_pointer[ADDR_WIDTH-1:0]),
    .wdata (din),
    .re    (fire),
    .raddr (read_pointer[ADDR_WIDTH-1:0]),
    .rdata (dout)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_EMPTY;
      write_pointer <= '0;
      base          <= '0;
      idx           <= '0;
      dout_valid    <= 1'b0;
      co_filter     <= 1'b0;
    end else begin
      dout_valid <= fire;
      co_filter  <= fire && last;

      if (write_counter_en && write_ok) begin
        write_pointer <= write_pointer + POINTER_SIZE'(1);
      end

      unique case (state)
        S_EMPTY: begin
          if (write_counter_en) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (end_of_filter) begin
            state <= S_FLUSH;
          end else if (fire) begin
            if (last) begin
              idx <= '0;
              if (next_filter) base <= base + fs_ext;
            end else begin
              idx <= idx + POINTER_SIZE'(1);
            end
          end
        end
        S_FLUSH: begin
          write_pointer <= '0;
          base          <= '0;
          idx           <= '0;
          state         <= S_EMPTY;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

`ifdef FILTER_SP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((write_counter_en && full) ||
                 ((write_en || write_counter_en) && (state == S_FLUSH)) ||
                 (read_req && !av_filter && (state == S_ACTIVE))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_filter_scratchpad_unit.sv
// Directed self-checking bench for filter_scratchpad_unit (SP_SIZE=8, filter_size=3).
module tb_filter_scratchpad_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic        write_counter_en;
  logic [15:0] din;
  logic [7:0]  filter_size;
  logic        av_filter;
  logic        end_of_filter;
  logic        read_req;
  logic        next_filter;
  logic [7:0]  write_pointer;
  logic [7:0]  read_pointer;
  logic [15:0] dout;
  logic        dout_valid;
  logic        co_filter;
  logic        busy;
`ifdef FILTER_SP_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_scratchpad_unit #(
    .SP_SIZE              (8),
    .DATA_WIDTH           (16),
    .FILTER_SIZE_REG_SIZE (8),
    .POINTER_SIZE         (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .write_en         (write_en),
    .write_counter_en (write_counter_en),
    .din              (din),
    .filter_size      (filter_size),
    .av_filter        (av_filter),
    .end_of_filter    (end_of_filter),
    .read_req         (read_req),
    .next_filter      (next_filter),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .co_filter        (co_filter),
    .busy             (busy)
`ifdef FILTER_SP_ERR_EN
    , .err            (err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [15:0] value);
    write_en = 1'b1; write_counter_en = 1'b1; din = value;
    tick();
    write_en = 1'b0; write_counter_en = 1'b0;
  endtask

  // One fired read: data appears one cycle later together with dout_valid.
  task automatic read_step(input string tag, input logic nf, input int exp_dout,
                           input logic exp_co, input int exp_rp);
    read_req = 1'b1; av_filter = 1'b1; next_filter = nf;
    tick();
    read_req = 1'b0; next_filter = 1'b0;
    check({tag, "_dout"}, dout, exp_dout);
    check({tag, "_valid"}, dout_valid, 1);
    check({tag, "_co"}, co_filter, exp_co);
    check({tag, "_rp"}, read_pointer, exp_rp);
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; write_counter_en = 1'b0; din = '0;
    filter_size = 8'd3; av_filter = 1'b0; end_of_filter = 1'b0;
    read_req = 1'b0; next_filter = 1'b0;
    tick(); tick();

    // Reset asserted for two cycles in the middle of a write burst.
    rst = 1'b0;
    write_en = 1'b1; write_counter_en = 1'b1; din = 16'd99;
    tick(); tick();
    check("pre_rst_wp", write_pointer, 2);
    rst = 1'b1;
    tick(); tick();
    check("rst_wp", write_pointer, 0);
    check("rst_rp", read_pointer, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_co", co_filter, 0);
    rst = 1'b0; write_en = 1'b0; write_counter_en = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) write_word(16'(10 + i));
    check("wr6_wp", write_pointer, 6);
    check("wr6_busy", busy, 1);
    check("wr6_rp", read_pointer, 0);
`ifdef FILTER_SP_ERR_EN
    check("err_clear", err, 0);
`endif

    // Window reused: base holds.
    read_step("r0", 1'b0, 10, 1'b0, 1);
    read_step("r1", 1'b0, 11, 1'b0, 2);
    read_step("r2", 1'b0, 12, 1'b1, 0);
    tick();
    check("idle_valid", dout_valid, 0);
    check("idle_co", co_filter, 0);
    check("idle_dout", dout, 12);

    // Advance to the next filter on the wrap.
    read_step("a0", 1'b0, 10, 1'b0, 1);
    read_step("a1", 1'b0, 11, 1'b0, 2);
    read_step("a2", 1'b1, 12, 1'b1, 3);
    read_step("b0", 1'b0, 13, 1'b0, 4);
    read_step("b1", 1'b0, 14, 1'b0, 5);
    read_step("b2", 1'b0, 15, 1'b1, 3);

    // Fill to SP_SIZE, then one more write_counter_en is ignored.
    write_word(16'd16);
    write_word(16'd17);
    check("full_wp", write_pointer, 8);
    write_word(16'd99);
    check("over_wp", write_pointer, 8);
`ifdef FILTER_SP_ERR_EN
    check("err_full", err, 1);
`endif

    // Move base to 6, then end_of_filter collides with a read.
    read_step("c0", 1'b0, 13, 1'b0, 4);
    read_step("c1", 1'b0, 14, 1'b0, 5);
    read_step("c2", 1'b1, 15, 1'b1, 6);
    end_of_filter = 1'b1; read_req = 1'b1; av_filter = 1'b1;
    tick();
    end_of_filter = 1'b0; read_req = 1'b0;
    check("eof_valid", dout_valid, 0);
    check("eof_busy", busy, 1);
    check("eof_rp", read_pointer, 6);
    check("eof_dout", dout, 15);
    write_en = 1'b1; write_counter_en = 1'b1; din = 16'd55;
    tick();
    write_en = 1'b0; write_counter_en = 1'b0;
    check("flush_wp", write_pointer, 0);
    check("flush_rp", read_pointer, 0);
    check("flush_busy", busy, 0);
    check("flush_valid", dout_valid, 0);
    check("flush_co", co_filter, 0);

    write_word(16'd20);
    write_word(16'd21);
    write_word(16'd22);
    check("wr3_wp", write_pointer, 3);
    read_step("d0", 1'b0, 20, 1'b0, 1);
    read_step("d1", 1'b0, 21, 1'b0, 2);
    read_step("d2", 1'b1, 22, 1'b1, 3);

    // No filter available: request is not served and idx stays put.
    read_req = 1'b1; av_filter = 1'b0;
    tick();
    read_req = 1'b0;
    check("noav_valid", dout_valid, 0);
    check("noav_rp", read_pointer, 3);
    check("noav_dout", dout, 22);

    // Write and read of address 3 in the same cycle: old word (13) comes back.
    write_en = 1'b1; write_counter_en = 1'b1; din = 16'd77;
    read_req = 1'b1; av_filter = 1'b1;
    tick();
    write_en = 1'b0; write_counter_en = 1'b0; read_req = 1'b0;
    check("rbw_dout", dout, 13);
    check("rbw_valid", dout_valid, 1);
    check("rbw_wp", write_pointer, 4);
    check("rbw_rp", read_pointer, 4);
    read_step("e1", 1'b0, 14, 1'b0, 5);
    read_step("e2", 1'b0, 15, 1'b1, 3);
    read_step("e3", 1'b0, 77, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
